// File: rtl/ndata_width_converter_ratio_if.sv
// Stream bus carrying WIDTH lanes of data_t per beat.
//
// Handshake: a beat transfers on a rising clk edge where valid && ready are
// both high. While valid is high and ready is low the master holds data,
// keep, last and valid stable. valid never depends combinationally on ready.
//
// Signals:
//   data   WIDTH x data_t  lanes, lane 0 = first element
//   keep   WIDTH           per-lane valid mask
//   last   1               last beat of a packet
//   valid  1               beat valid (master -> slave)
//   ready  1               beat accepted (slave -> master)
interface ndata_width_converter_ratio_if #(
  parameter type data_t = logic [31:0],
  parameter int  WIDTH  = 8
);
  data_t [WIDTH-1:0] data;
  logic  [WIDTH-1:0] keep;
  logic              last;
  logic              valid;
  logic              ready;

  modport master (output data, keep, last, valid, input ready);
  modport slave  (input data, keep, last, valid, output ready);
endinterface

// File: rtl/ndata_width_converter_ratio.sv
// Generic lane-count converter between two streams whose widths divide evenly.
//   - OUT = R*IN (upsize): R input beats are packed into one output beat;
//     in.last flushes a partially filled beat early.
//   - IN = R*OUT (downsize): each input beat is split into R slices; a last
//     beat stops after its highest slice that carries any kept lane.
//   - IN == OUT: combinational pass-through.
//
// Ports:
//   clk    clock, all state on the rising edge
//   rst_n  asynchronous active-low reset, discards any partial beat
//   in     slave stream, IN_WIDTH lanes
//   out    master stream, OUT_WIDTH lanes, out.valid comes from a register
module ndata_width_converter_ratio #(
  parameter type data_t    = logic [31:0],
  parameter int  IN_WIDTH  = 8,
  parameter int  OUT_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  ndata_width_converter_ratio_if.slave  in,
  ndata_width_converter_ratio_if.master out
);

  localparam int MAX_W  = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
  localparam int MIN_W  = (IN_WIDTH > OUT_WIDTH) ? OUT_WIDTH : IN_WIDTH;
  localparam int R      = MAX_W / MIN_W;
  localparam int SLOT_W = (R > 1) ? $clog2(R) : 1;

  if ((MAX_W % MIN_W) != 0) begin : g_bad_ratio
    $error("ndata_width_converter_ratio: widths %0d and %0d are not integer multiples",
           IN_WIDTH, OUT_WIDTH);
  end

  if (IN_WIDTH == OUT_WIDTH) begin : g_pass
    assign out.data  = in.data;
    assign out.keep  = in.keep;
    assign out.last  = in.last;
    assign out.valid = in.valid;
    assign in.ready  = out.ready;

  end else if (OUT_WIDTH > IN_WIDTH) begin : g_up
    // The packing buffer is also the output register: once a beat is
    // complete it is presented on out.* until taken.
    data_t [OUT_WIDTH-1:0] buf_data;
    logic  [OUT_WIDTH-1:0] buf_keep;
    logic                  buf_last;
    logic                  buf_valid;
    logic  [SLOT_W-1:0]    slot;
    logic                  in_accept;
    logic                  slot_full;

    // Slot counter only advances while buf_valid is low, so a slot-0 write
    // is the only write that can coincide with an outgoing beat.
    assign in.ready  = !buf_valid || out.ready;
    assign in_accept = in.valid && in.ready;
    assign slot_full = (slot == SLOT_W'(R - 1));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        buf_keep  <= '0;
        buf_last  <= 1'b0;
        buf_valid <= 1'b0;
        slot      <= '0;
      end else begin
        if (buf_valid && out.ready) begin
          buf_valid <= 1'b0;
          buf_last  <= 1'b0;
        end
        if (in_accept) begin
          // Starting a new beat wipes the keep of every higher slot so an
          // early flush shows unfilled slots as empty.
          if (slot == '0) begin
            buf_keep <= {{(OUT_WIDTH - IN_WIDTH){1'b0}}, in.keep};
          end else begin
            buf_keep[int'(slot)*IN_WIDTH +: IN_WIDTH] <= in.keep;
          end
          if (slot_full || in.last) begin
            buf_valid <= 1'b1;
            buf_last  <= in.last;
            slot      <= '0;
          end else begin
            slot <= slot + SLOT_W'(1);
          end
        end
      end
    end

    // Lane payload carries no control meaning, so it is left unreset.
    always_ff @(posedge clk) begin
      if (in_accept) begin
        buf_data[int'(slot)*IN_WIDTH +: IN_WIDTH] <= in.data;
      end
    end

    assign out.data  = buf_data;
    assign out.keep  = buf_keep;
    assign out.last  = buf_last;
    assign out.valid = buf_valid;

  end else begin : g_down
    data_t [IN_WIDTH-1:0] hold_data;
    logic  [IN_WIDTH-1:0] hold_keep;
    logic                 hold_last;
    logic                 held;
    logic  [SLOT_W-1:0]   slice;
    logic  [SLOT_W-1:0]   final_slice;
    logic  [SLOT_W-1:0]   accept_final;
    logic                 at_final;
    logic                 in_accept;
    logic                 out_fire;

    // Index of the slice that ends the incoming beat: all R slices for a
    // non-last beat, otherwise the highest slice with any kept lane. An
    // all-empty last beat still yields slice 0 so the last marker survives.
    always_comb begin
      accept_final = SLOT_W'(R - 1);
      if (in.last) begin
        accept_final = '0;
        for (int s = 0; s < R; s++) begin
          if (|in.keep[s*OUT_WIDTH +: OUT_WIDTH]) begin
            accept_final = SLOT_W'(s);
          end
        end
      end
    end

    assign at_final  = (slice == final_slice);
    assign out_fire  = held && out.ready;
    // A new beat may load in the same cycle the final slice leaves.
    assign in.ready  = !held || (out.ready && at_final);
    assign in_accept = in.valid && in.ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        held        <= 1'b0;
        slice       <= '0;
        final_slice <= '0;
        hold_keep   <= '0;
        hold_last   <= 1'b0;
      end else if (in_accept) begin
        held        <= 1'b1;
        slice       <= '0;
        final_slice <= accept_final;
        hold_keep   <= in.keep;
        hold_last   <= in.last;
      end else if (out_fire) begin
        if (at_final) begin
          held <= 1'b0;
        end else begin
          slice <= slice + SLOT_W'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (in_accept) begin
        hold_data <= in.data;
      end
    end

    assign out.data  = hold_data[int'(slice)*OUT_WIDTH +: OUT_WIDTH];
    assign out.keep  = hold_keep[int'(slice)*OUT_WIDTH +: OUT_WIDTH];
    assign out.last  = held && hold_last && at_final;
    assign out.valid = held;
  end

endmodule
